// File: rtl/vc_alloc_ctrl.sv
// Router virtual-channel allocator: owns every output VC, grants at most one free
// OVC per output port per cycle by round-robin and releases it on unlock.
module vc_alloc_ctrl #(
  parameter int NUM_PORTS  = 5,
  parameter int NUM_VCS    = 2,
  parameter int VC_ID_BITS = 1,
  parameter int DIR_BITS   = 3
) (
  input  logic                                   clk,
  input  logic                                   arst_n,
  input  logic [NUM_PORTS*NUM_VCS*DIR_BITS-1:0]   req_dir,
  input  logic [NUM_PORTS*NUM_VCS-1:0]            unlock,
  output logic [NUM_PORTS*NUM_VCS-1:0]            vc_allocated,
  output logic [NUM_PORTS*NUM_VCS*VC_ID_BITS-1:0] vc_allocated_id,
  output logic [NUM_PORTS*NUM_VCS-1:0]            out_vc_free,
  output logic                                    proto_err
);

  localparam int R      = NUM_PORTS * NUM_VCS;
  localparam int PTR_W  = (R > 1) ? $clog2(R) : 1;
  localparam int PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [R-1:0]                            busy_q, busy_d;
  logic [R-1:0]                            held_q, held_d;
  logic [R-1:0][PORT_W-1:0]                hold_port_q, hold_port_d;
  logic [R-1:0][VC_ID_BITS-1:0]            hold_vc_q, hold_vc_d;
  logic [NUM_PORTS-1:0][PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [R-1:0]                            alloc_q, alloc_d;
  logic [R-1:0][VC_ID_BITS-1:0]            alloc_id_q, alloc_id_d;
  logic                                    err_q, err_d;

  logic [R-1:0][DIR_BITS-1:0]              dir_s;
  logic [NUM_PORTS-1:0][R-1:0]             elig_s;
  logic                                    free_found_s;
  logic [VC_ID_BITS-1:0]                   free_k_s;
  logic                                    win_found_s;
  logic [PTR_W-1:0]                        win_s;
  logic [PTR_W:0]                          sum_s;

  // Next-state: releases, protocol checks and per-output round-robin grants.
  always_comb begin
    busy_d       = busy_q;
    held_d       = held_q;
    hold_port_d  = hold_port_q;
    hold_vc_d    = hold_vc_q;
    rr_ptr_d     = rr_ptr_q;
    alloc_d      = '0;
    alloc_id_d   = '0;
    err_d        = 1'b0;
    dir_s        = '0;
    elig_s       = '0;
    free_found_s = 1'b0;
    free_k_s     = '0;
    win_found_s  = 1'b0;
    win_s        = '0;
    sum_s        = '0;

    for (int r = 0; r < R; r++) begin
      dir_s[r] = req_dir[r*DIR_BITS +: DIR_BITS];
      if (unlock[r]) begin
        if (held_q[r]) begin
          held_d[r] = 1'b0;
          for (int o = 0; o < NUM_PORTS; o++) begin
            for (int k = 0; k < NUM_VCS; k++) begin
              if (hold_port_q[r] == PORT_W'(o) && hold_vc_q[r] == VC_ID_BITS'(k)) begin
                busy_d[o*NUM_VCS+k] = 1'b0;
              end else begin
                busy_d[o*NUM_VCS+k] = busy_d[o*NUM_VCS+k];
              end
            end
          end
        end else begin
          err_d = 1'b1;
        end
      end else begin
        // A request still visible while its own grant is shown is expected, not an error.
        if (dir_s[r] < DIR_BITS'(NUM_PORTS) && held_q[r] && !alloc_q[r]) begin
          err_d = 1'b1;
        end else begin
          err_d = err_d;
        end
      end
    end

    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int r = 0; r < R; r++) begin
        elig_s[o][r] = (dir_s[r] == DIR_BITS'(o)) && !held_q[r] && !alloc_q[r];
      end

      free_found_s = 1'b0;
      free_k_s     = '0;
      for (int k = NUM_VCS - 1; k >= 0; k--) begin
        if (!busy_q[o*NUM_VCS+k]) begin
          free_found_s = 1'b1;
          free_k_s     = VC_ID_BITS'(k);
        end else begin
          free_found_s = free_found_s;
        end
      end

      win_found_s = 1'b0;
      win_s       = '0;
      if (free_found_s) begin
        for (int i = 0; i < R; i++) begin
          sum_s = {1'b0, rr_ptr_q[o]} + (PTR_W+1)'(i);
          if (sum_s >= (PTR_W+1)'(R)) begin
            sum_s = sum_s - (PTR_W+1)'(R);
          end else begin
            sum_s = sum_s;
          end
          if (!win_found_s && elig_s[o][sum_s[PTR_W-1:0]]) begin
            win_found_s = 1'b1;
            win_s       = sum_s[PTR_W-1:0];
          end else begin
            win_found_s = win_found_s;
          end
        end
      end else begin
        win_found_s = 1'b0;
      end

      if (win_found_s) begin
        alloc_d[win_s]     = 1'b1;
        alloc_id_d[win_s]  = free_k_s;
        held_d[win_s]      = 1'b1;
        hold_port_d[win_s] = PORT_W'(o);
        hold_vc_d[win_s]   = free_k_s;
        for (int k = 0; k < NUM_VCS; k++) begin
          if (free_k_s == VC_ID_BITS'(k)) begin
            busy_d[o*NUM_VCS+k] = 1'b1;
          end else begin
            busy_d[o*NUM_VCS+k] = busy_d[o*NUM_VCS+k];
          end
        end
        rr_ptr_d[o] = (win_s == PTR_W'(R - 1)) ? '0 : win_s + PTR_W'(1);
      end else begin
        rr_ptr_d[o] = rr_ptr_q[o];
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      busy_q      <= '0;
      held_q      <= '0;
      hold_port_q <= '0;
      hold_vc_q   <= '0;
      rr_ptr_q    <= '0;
      alloc_q     <= '0;
      alloc_id_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      held_q      <= held_d;
      hold_port_q <= hold_port_d;
      hold_vc_q   <= hold_vc_d;
      rr_ptr_q    <= rr_ptr_d;
      alloc_q     <= alloc_d;
      alloc_id_q  <= alloc_id_d;
      err_q       <= err_d;
    end
  end

  assign vc_allocated    = alloc_q;
  assign vc_allocated_id = alloc_id_q;
  assign out_vc_free     = ~busy_q;
  assign proto_err       = err_q;

endmodule
